nios2_jtag_debug_sysclk_bridge: RTL and testbench

Parametrised system-clock side of the Nios II JTAG debug path. Synchronises the virtual-JTAG update strobes (UDR, UIR) from the TCK domain and captures {ir_in, sr} into a small command FIFO. Presents commands to the OCI/trace/break logic with a valid/ready handshake instead of fire-and-forget action pulses. Adds configurable synchroniser depth and buffering for back-to-back scans, plus sticky overrun reporting.

---
 rtl/nios2_jtag_dbg_pkg.sv | 25 ++
 rtl/nios2_jtag_dbg_sync.sv | 47 ++++
 rtl/nios2_jtag_debug_sysclk_bridge.sv | 120 ++++++++++++
 tb/tb_nios2_jtag_debug_sysclk_bridge.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_jtag_dbg_pkg.sv
// Shared constants for the Nios II JTAG debug path.
// - Default register widths for the virtual-JTAG scan chain.
// - IR command codes that select the OCI target of a scan.
// - Bit positions of the jdo fields that consumers decode.
package nios2_jtag_dbg_pkg;

   localparam int DEFAULT_DR_WIDTH = 38;
   localparam int DEFAULT_IR_WIDTH = 2;

   typedef enum logic [1:0] {
      IR_OCIMEM    = 2'd0,
      IR_TRACEMEM  = 2'd1,
      IR_BREAK     = 2'd2,
      IR_TRACECTRL = 2'd3
   } ir_code_e;

   // jdo layout: control flags on top, a 32-bit data word, small aux field below it
   localparam int JDO_CTRL_MSB = 37;
   localparam int JDO_CTRL_LSB = 35;
   localparam int JDO_DATA_MSB = 34;
   localparam int JDO_DATA_LSB = 3;
   localparam int JDO_AUX_MSB  = 2;
   localparam int JDO_AUX_LSB  = 0;

endpackage

// File: rtl/nios2_jtag_dbg_sync.sv
// Single-bit synchroniser with rise detection and arming.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   async_in     : strobe from the TCK domain
//   rise         : one-cycle pulse on each armed rise of the synchronised strobe
module nios2_jtag_dbg_sync
   import nios2_jtag_dbg_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic async_in,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] prime_q;
   logic                   prev_q;
   logic                   armed_q;
   logic                   sync_out;
   logic                   primed;

   assign sync_out = sync_q[SYNC_STAGES-1];
   // The chain resets to zero, so its output only reflects the real input once
   // a post-reset sample has reached the last flop. Arming waits for that, so a
   // strobe held high across reset is never mistaken for a fresh low.
   assign primed   = prime_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q  <= '0;
         prime_q <= '0;
         prev_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
         prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
         prev_q  <= sync_out;
         if (primed && !sync_out)
            armed_q <= 1'b1;
      end
   end

   assign rise = armed_q && sync_out && !prev_q;

endmodule

// File: rtl/nios2_jtag_debug_sysclk_bridge.sv
// System-clock side of the Nios II JTAG debug path.
// Synchronises the Update-DR / Update-IR strobes, captures {ir_in, sr} into a
// command FIFO on each Update-DR and presents the head entry with valid/ready.
// Ports:
//   clk, reset_n          : system clock, asynchronous active-low reset
//   vs_udr, vs_uir        : TCK-domain update strobes
//   ir_in, sr             : scanned IR and DR, stable around the update
//   cmd_valid, cmd_ready  : head-entry handshake
//   cmd_ir, cmd_sel, jdo  : head entry fields (cmd_sel one-hot, zero when idle)
//   ir_update             : one-cycle pulse per Update-IR
//   fifo_level            : occupied entries
//   overrun, overrun_clr  : sticky drop flag and its clear
module nios2_jtag_debug_sysclk_bridge
   import nios2_jtag_dbg_pkg::*;
#(
   parameter int DR_WIDTH    = DEFAULT_DR_WIDTH,
   parameter int IR_WIDTH    = DEFAULT_IR_WIDTH,
   parameter int SYNC_STAGES = 2,
   parameter int CMD_DEPTH   = 4
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             vs_udr,
   input  logic                             vs_uir,
   input  logic [IR_WIDTH-1:0]              ir_in,
   input  logic [DR_WIDTH-1:0]              sr,
   output logic                             cmd_valid,
   input  logic                             cmd_ready,
   output logic [IR_WIDTH-1:0]              cmd_ir,
   output logic [(2**IR_WIDTH)-1:0]         cmd_sel,
   output logic [DR_WIDTH-1:0]              jdo,
   output logic                             ir_update,
   output logic [$clog2(CMD_DEPTH+1)-1:0]   fifo_level,
   output logic                             overrun,
   input  logic                             overrun_clr
);

   localparam int AW      = $clog2(CMD_DEPTH);
   localparam int LVL_W   = $clog2(CMD_DEPTH+1);
   localparam int ENTRY_W = IR_WIDTH + DR_WIDTH;

   logic                udr_rise;
   logic                uir_rise;
   logic [AW:0]         wr_ptr;
   logic [AW:0]         rd_ptr;
   logic [LVL_W-1:0]    level_q;
   logic [ENTRY_W-1:0]  mem [CMD_DEPTH];
   logic [ENTRY_W-1:0]  head;
   logic                full;
   logic                pop;
   logic                push;
   logic                drop;

   // ---- strobe synchronisers ----
   nios2_jtag_dbg_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
      .clk      (clk),
      .reset_n  (reset_n),
      .async_in (vs_udr),
      .rise     (udr_rise)
   );

   nios2_jtag_dbg_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
      .clk      (clk),
      .reset_n  (reset_n),
      .async_in (vs_uir),
      .rise     (uir_rise)
   );

   // ---- command FIFO ----
   // Extra pointer MSB separates full (MSBs differ) from empty (equal).
   assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign cmd_valid = (wr_ptr != rd_ptr);
   assign pop  = cmd_valid && cmd_ready;
   // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
   assign push = udr_rise && (!full || pop);
   assign drop = udr_rise && full && !pop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level_q   <= '0;
         overrun   <= 1'b0;
         ir_update <= 1'b0;
         for (int i = 0; i < CMD_DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= {ir_in, sr};
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
         // A new drop outranks a simultaneous clear.
         if (drop)
            overrun <= 1'b1;
         else if (overrun_clr)
            overrun <= 1'b0;
         ir_update <= uir_rise;
      end
   end

   // ---- head presentation ----
   assign head       = mem[rd_ptr[AW-1:0]];
   assign cmd_ir     = head[ENTRY_W-1 -: IR_WIDTH];
   assign jdo        = head[DR_WIDTH-1:0];
   assign fifo_level = level_q;

   always_comb begin
      cmd_sel = '0;
      if (cmd_valid)
         cmd_sel[cmd_ir] = 1'b1;
   end

endmodule

// File: tb/tb_nios2_jtag_debug_sysclk_bridge.sv
module tb_nios2_jtag_debug_sysclk_bridge;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        vs_udr;
   logic        vs_uir;
   logic [1:0]  ir_in;
   logic [37:0] sr;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_ir;
   logic [3:0]  cmd_sel;
   logic [37:0] jdo;
   logic        ir_update;
   logic [2:0]  fifo_level;
   logic        overrun;
   logic        overrun_clr;

   int n_cmp = 0;
   int n_err = 0;

   logic [37:0] vals [8];
   logic [1:0]  irs  [8];

   always #5 clk = ~clk;

   nios2_jtag_debug_sysclk_bridge #(
      .DR_WIDTH(38), .IR_WIDTH(2), .SYNC_STAGES(2), .CMD_DEPTH(4)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .vs_udr      (vs_udr),
      .vs_uir      (vs_uir),
      .ir_in       (ir_in),
      .sr          (sr),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_ir      (cmd_ir),
      .cmd_sel     (cmd_sel),
      .jdo         (jdo),
      .ir_update   (ir_update),
      .fifo_level  (fifo_level),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_udr(input logic [37:0] d, input logic [1:0] ir);
      sr     = d;
      ir_in  = ir;
      vs_udr = 1'b1;
      repeat (3) tick();
      vs_udr = 1'b0;
      repeat (5) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_hi;
      int hi_cnt;

      vals[0] = 38'h0_AAAA_0001; irs[0] = 2'd0;
      vals[1] = 38'h1_5555_0002; irs[1] = 2'd1;
      vals[2] = 38'h2_0F0F_0003; irs[2] = 2'd2;
      vals[3] = 38'h3_F0F0_0004; irs[3] = 2'd3;
      vals[4] = 38'h0_DEAD_0005; irs[4] = 2'd0;
      vals[5] = 38'h1_2345_6789; irs[5] = 2'd3;
      vals[6] = 38'h3_CAFE_0006; irs[6] = 2'd1;
      vals[7] = 38'h0_0BAD_F00D; irs[7] = 2'd0;

      // Reset with vs_udr held high through it
      reset_n     = 1'b0;
      vs_udr      = 1'b1;
      vs_uir      = 1'b0;
      sr          = 38'h2_1234_5678;
      ir_in       = 2'd1;
      cmd_ready   = 1'b0;
      overrun_clr = 1'b0;
      repeat (2) tick();
      chk("rst_valid", cmd_valid, 0);
      chk("rst_jdo", jdo, 0);
      chk("rst_ir", cmd_ir, 0);
      chk("rst_sel", cmd_sel, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_irupd", ir_update, 0);

      reset_n = 1'b1;
      repeat (6) tick();
      chk("held_high_no_push_valid", cmd_valid, 0);
      chk("held_high_no_push_level", fifo_level, 0);
      vs_udr = 1'b0;
      repeat (4) tick();
      vs_udr = 1'b1;
      tick();
      tick();
      chk("latency_edge2_valid", cmd_valid, 0);
      tick();
      chk("latency_edge3_valid", cmd_valid, 1);
      chk("first_jdo", jdo, 38'h2_1234_5678);
      chk("first_sel", cmd_sel, 4'b0010);
      chk("first_ir", cmd_ir, 2'd1);
      chk("first_level", fifo_level, 1);
      vs_udr = 1'b0;
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      chk("pop_valid", cmd_valid, 0);
      chk("pop_level", fifo_level, 0);
      chk("pop_sel_idle", cmd_sel, 0);
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      chk("ready_when_empty_level", fifo_level, 0);
      chk("ready_when_empty_valid", cmd_valid, 0);
      repeat (3) tick();

      // Fill the FIFO and overflow it
      for (int k = 0; k < 4; k++) pulse_udr(vals[k], irs[k]);
      chk("fill4_level", fifo_level, 4);
      chk("fill4_overrun", overrun, 0);
      pulse_udr(vals[4], irs[4]);
      chk("ovf_level", fifo_level, 4);
      chk("ovf_overrun", overrun, 1);
      chk("ovf_head_jdo", jdo, vals[0]);
      tick();
      chk("hold_head_jdo", jdo, vals[0]);
      chk("hold_head_ir", cmd_ir, irs[0]);

      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      chk("ovf_clear", overrun, 0);

      // Full: push lands on the same edge as a pop
      sr = vals[5]; ir_in = irs[5]; vs_udr = 1'b1;
      tick();
      tick();
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      chk("pushpop_overrun", overrun, 0);
      chk("pushpop_level", fifo_level, 4);
      chk("pushpop_head", jdo, vals[1]);
      vs_udr = 1'b0;
      repeat (5) tick();

      // Full: overflow coincides with overrun_clr
      sr = vals[6]; ir_in = irs[6]; vs_udr = 1'b1;
      tick();
      tick();
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      chk("set_beats_clr", overrun, 1);
      chk("set_beats_clr_level", fifo_level, 4);
      vs_udr = 1'b0;
      repeat (5) tick();

      // Pop one and check order continues
      chk("order_head1", jdo, vals[1]);
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      chk("order_head2_jdo", jdo, vals[2]);
      chk("order_head2_ir", cmd_ir, irs[2]);
      chk("order_head2_sel", cmd_sel, 4'b0100);
      chk("order_level3", fifo_level, 3);

      // Update-IR pulse, three clocks long
      first_hi = 0;
      hi_cnt   = 0;
      vs_uir   = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         if (i == 4) vs_uir = 1'b0;
         tick();
         if (ir_update === 1'b1) begin
            hi_cnt++;
            if (first_hi == 0) first_hi = i;
         end
      end
      chk("irupd_width", hi_cnt, 1);
      chk("irupd_latency", first_hi, 3);
      chk("irupd_level", fifo_level, 3);

      // Asynchronous reset mid-handshake
      chk("pre_reset_valid", cmd_valid, 1);
      cmd_ready = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_valid", cmd_valid, 0);
      chk("async_rst_level", fifo_level, 0);
      chk("async_rst_jdo", jdo, 0);
      chk("async_rst_overrun", overrun, 0);
      tick();
      cmd_ready = 1'b0;
      reset_n   = 1'b1;
      repeat (5) tick();

      sr = vals[7]; ir_in = irs[7]; vs_udr = 1'b1;
      tick();
      tick();
      chk("post_rst_edge2_valid", cmd_valid, 0);
      tick();
      chk("post_rst_valid", cmd_valid, 1);
      chk("post_rst_jdo", jdo, vals[7]);
      chk("post_rst_sel", cmd_sel, 4'b0001);
      chk("post_rst_level", fifo_level, 1);
      vs_udr = 1'b0;
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
